risc8_fetch: RTL and testbench

Instruction prefetch and align stage directly upstream of the risc8 datapath. Reads 16-bit words from a synchronous program ROM into a byte queue and presents the head opcode byte to the decoder. Once all bytes of the instruction are queued, it also presents up to three immediate bytes as immr[23:0]. Branches, interrupts and returns enter as a redirect carrying the new byte PC.

---
 rtl/risc8_fetch.sv | 172 +++++++++++++++++
 tb/tb_risc8_fetch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/risc8_fetch.sv
// -----------------------------------------------------------------------------
// risc8_fetch -- instruction prefetch / align stage for the risc8 datapath.
//
// Reads 16-bit words from a synchronous program ROM into a byte queue and
// presents the head opcode, its immediate bytes and its byte PC to the
// decoder. The decoder answers with the instruction length code (isize).
// A redirect flushes the queue and restarts fetch at a new byte PC.
//
// Parameters:
//   DEPTH   byte-queue capacity (power of two, >= 6)
//   ROM_AW  ROM word-address width (byte PC is ROM_AW+1 bits, ROM_AW <= 15)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   redirect        flush queue and restart fetch at redirect_pc
//   redirect_pc     new byte PC
//   rom_rd_en       ROM read strobe
//   rom_addr        ROM word address
//   rom_rdata       ROM data, valid the cycle after rom_rd_en
//                   ([7:0] even byte, [15:8] odd byte)
//   head_op         queue head byte (0 when queue empty)
//   isize           decoder length code for head_op (length = isize+1)
//   instr_valid     queue holds the whole current instruction
//   immr            immediate bytes 1..3 (bytes beyond the length read 0)
//   fetch_pc        byte PC of head_op
//   advance         consume the current instruction
//   stall_cnt       bubble counter
//
// Build option:
//   FETCH_STALL_CNT_EN  when defined, stall_cnt counts cycles with no valid
//                       instruction (saturating); otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module risc8_fetch #(
    parameter int DEPTH  = 8,
    parameter int ROM_AW = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [15:0]       redirect_pc,
    output logic              rom_rd_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_rdata,
    output logic [7:0]        head_op,
    input  logic [1:0]        isize,
    output logic              instr_valid,
    output logic [23:0]       immr,
    output logic [15:0]       fetch_pc,
    input  logic              advance,
    output logic [15:0]       stall_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Queue storage is data only and carries no reset.
    logic [7:0]    r_q [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [15:0]   r_fetch_pc;
    logic [14:0]   r_issue_word;   // issue_pc[15:1]; issue_pc[0] is always 0
    logic          r_pending;      // ROM data for the last issue is on rom_rdata now
    logic          r_odd;          // that read started at an odd byte

    logic [CW-1:0] w_len;
    logic [CW-1:0] w_push_n;
    logic [CW:0]   w_fill;
    logic          w_room;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;

    // ------------------------------------------------------------------
    // Issue: keep room for the in-flight word plus the word issued now
    // ------------------------------------------------------------------
    assign w_fill    = {1'b0, r_count} + (r_pending ? (CW+1)'(2) : '0);
    assign w_room    = (w_fill <= (CW+1)'(DEPTH - 2));
    assign rom_rd_en = !rst && (redirect || w_room);
    assign rom_addr  = redirect ? redirect_pc[ROM_AW:1] : r_issue_word[ROM_AW-1:0];

    // ------------------------------------------------------------------
    // Return / consume
    // ------------------------------------------------------------------
    // The ROM has single-cycle latency, so the only response that can be in
    // flight across a redirect is the one on rom_rdata in the redirect cycle
    // itself; gating the push with redirect discards it.
    assign w_len       = CW'(isize) + CW'(1);
    assign w_push_n    = r_odd ? CW'(1) : CW'(2);
    assign w_push      = r_pending && !redirect;
    assign instr_valid = (r_count >= w_len);
    assign w_pop       = advance && instr_valid && !redirect;
    assign w_count_nxt = r_count + (w_push ? w_push_n : '0) - (w_pop ? w_len : '0);

    assign fetch_pc = r_fetch_pc;
    assign head_op  = (r_count != '0) ? r_q[r_head] : 8'h00;

    // Immediate byte k is shown only if it belongs to the instruction and
    // is already in the queue.
    always_comb begin
        immr = '0;
        for (int k = 1; k < 4; k++) begin
            if (k <= int'(isize) && CW'(k) < r_count)
                immr[8*k-8 +: 8] = r_q[r_head + AW'(k)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_fetch_pc   <= '0;
            r_issue_word <= '0;
            r_pending    <= 1'b0;
            r_odd        <= 1'b0;
        end else begin
            r_pending <= rom_rd_en;
            // Only a redirect can start a read at an odd byte.
            r_odd     <= redirect & redirect_pc[0];
            if (redirect) begin
                r_head       <= '0;
                r_tail       <= '0;
                r_count      <= '0;
                r_fetch_pc   <= redirect_pc;
                r_issue_word <= redirect_pc[15:1] + 15'd1;
            end else begin
                if (rom_rd_en)
                    r_issue_word <= r_issue_word + 15'd1;
                if (w_push)
                    r_tail <= r_tail + w_push_n[AW-1:0];
                if (w_pop) begin
                    r_head     <= r_head + w_len[AW-1:0];
                    r_fetch_pc <= r_fetch_pc + 16'(w_len);
                end
                r_count <= w_count_nxt;
            end
        end
    end

    // Queue write: an odd-start word contributes only its high byte.
    always_ff @(posedge clk) begin
        if (w_push) begin
            if (r_odd) begin
                r_q[r_tail] <= rom_rdata[15:8];
            end else begin
                r_q[r_tail]           <= rom_rdata[7:0];
                r_q[r_tail + AW'(1)]  <= rom_rdata[15:8];
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (!instr_valid && !redirect)
            r_stall_cnt <= sat_inc16(r_stall_cnt);
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_risc8_fetch.sv
module tb_risc8_fetch;
    localparam int DEPTH  = 8;
    localparam int ROM_AW = 15;

    logic              clk;
    logic              rst;
    logic              redirect;
    logic [15:0]       redirect_pc;
    logic              rom_rd_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_rdata;
    logic [7:0]        head_op;
    logic [1:0]        isize;
    logic              instr_valid;
    logic [23:0]       immr;
    logic [15:0]       fetch_pc;
    logic              advance;
    logic [15:0]       stall_cnt;

    int n_tests;
    int n_fail;

    // Program memory as a flat byte array; the ROM model packs two bytes.
    logic [7:0] mem [65536];

    risc8_fetch #(.DEPTH(DEPTH), .ROM_AW(ROM_AW)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .head_op(head_op), .isize(isize), .instr_valid(instr_valid),
        .immr(immr), .fetch_pc(fetch_pc), .advance(advance), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (rom_rd_en) rom_rdata <= {mem[{rom_addr, 1'b1}], mem[{rom_addr, 1'b0}]};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] ref_immr(input logic [15:0] pc, input logic [1:0] isz);
        logic [23:0] r;
        r = '0;
        for (int k = 1; k <= int'(isz); k++) r[8*k-8 +: 8] = mem[16'(pc + 16'(k))];
        return r;
    endfunction

    task automatic test_reset;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; advance = 1'b0; isize = 2'd0;
        mem[0] = 8'h01; mem[1] = 8'h12;
        step; step; #1;
        n_tests++; if (rom_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b want 0", rom_rd_en); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        n_tests++; if (immr !== 24'h0) begin n_fail++; $display("FAIL rst_immr: got %h want 0", immr); end
        n_tests++; if (head_op !== 8'h00) begin n_fail++; $display("FAIL rst_head: got %h want 00", head_op); end
        n_tests++; if (fetch_pc !== 16'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0000", fetch_pc); end
        n_tests++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_stall: got %h want 0000", stall_cnt); end
        // cycle 1: first read
        rst = 1'b0; #1;
        n_tests++; if (rom_rd_en !== 1'b1 || rom_addr !== 15'h0) begin n_fail++; $display("FAIL first_read: got en=%b addr=%h want en=1 addr=0", rom_rd_en, rom_addr); end
        step; // cycle 2
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL c2_valid: got %b want 0", instr_valid); end
        step; // cycle 3
        n_tests++; if (instr_valid !== 1'b1 || head_op !== 8'h01 || fetch_pc !== 16'h0) begin n_fail++; $display("FAIL c3_first: got v=%b op=%h pc=%h want v=1 op=01 pc=0000", instr_valid, head_op, fetch_pc); end
        // reset while a read is returning: everything back to reset values
        rst = 1'b1; #1;
        n_tests++; if (rom_rd_en !== 1'b0) begin n_fail++; $display("FAIL midrst_rd_en: got %b want 0", rom_rd_en); end
        step;
        n_tests++; if (instr_valid !== 1'b0 || head_op !== 8'h00 || fetch_pc !== 16'h0) begin n_fail++; $display("FAIL midrst_state: got v=%b op=%h pc=%h want 0/00/0000", instr_valid, head_op, fetch_pc); end
        rst = 1'b0; #1;
        step;
        n_tests++; if (instr_valid !== 1'b0 || head_op !== 8'h00) begin n_fail++; $display("FAIL midrst_stale: got v=%b op=%h want 0/00", instr_valid, head_op); end
        step;
        n_tests++; if (instr_valid !== 1'b1 || head_op !== mem[0]) begin n_fail++; $display("FAIL midrst_refill: got v=%b op=%h want 1/%h", instr_valid, head_op, mem[0]); end
    endtask

    task automatic test_long_instr;
        mem[0] = 8'h05; mem[1] = 8'hAA; mem[2] = 8'hBB; mem[3] = 8'hCC;
        isize = 2'd3; advance = 1'b0;
        redirect = 1'b1; redirect_pc = 16'h0000; #1;
        step; redirect = 1'b0; #1;                 // T+1
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL long_t1: got %b want 0", instr_valid); end
        step;                                       // T+2
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL long_t2: got %b want 0", instr_valid); end
        step;                                       // T+3
        n_tests++; if (instr_valid !== 1'b1 || head_op !== 8'h05 || immr !== 24'hCCBBAA) begin n_fail++; $display("FAIL long_t3: got v=%b op=%h immr=%h want 1/05/ccbbaa", instr_valid, head_op, immr); end
        advance = 1'b1;
        step; advance = 1'b0; #1;
        n_tests++; if (fetch_pc !== 16'h0004) begin n_fail++; $display("FAIL long_adv: got pc=%h want 0004", fetch_pc); end
    endtask

    task automatic test_odd_redirect;
        isize = 2'd0; advance = 1'b0;
        redirect = 1'b1; redirect_pc = 16'h0103; #1;
        n_tests++; if (rom_rd_en !== 1'b1 || rom_addr !== 15'h0081) begin n_fail++; $display("FAIL odd_addr: got en=%b addr=%h want 1/0081", rom_rd_en, rom_addr); end
        step; redirect = 1'b0; #1;                 // T+1
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL odd_t1: got %b want 0", instr_valid); end
        step;                                       // T+2
        n_tests++; if (instr_valid !== 1'b1 || head_op !== mem[16'h0103] || fetch_pc !== 16'h0103 || immr !== 24'h0) begin n_fail++; $display("FAIL odd_t2: got v=%b op=%h pc=%h immr=%h want 1/%h/0103/0", instr_valid, head_op, fetch_pc, immr, mem[16'h0103]); end
        isize = 2'd1; #1;                           // only one byte queued so far
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL odd_len2_t2: got %b want 0", instr_valid); end
        step;                                       // T+3
        n_tests++; if (instr_valid !== 1'b1 || immr !== {16'h0, mem[16'h0104]}) begin n_fail++; $display("FAIL odd_len2_t3: got v=%b immr=%h want 1/%h", instr_valid, immr, {16'h0, mem[16'h0104]}); end
    endtask

    task automatic test_redirect_flush;
        mem[16'h2000] = 8'h11; mem[16'h2001] = 8'h22;
        mem[16'h3000] = 8'h99; mem[16'h3001] = 8'h77;
        isize = 2'd0; advance = 1'b0;
        redirect = 1'b1; redirect_pc = 16'h2000; #1;
        step;                                       // A's data returns now
        redirect_pc = 16'h3001; #1;                 // second redirect, same cycle
        step; redirect = 1'b0; #1;
        n_tests++; if (instr_valid !== 1'b0 || head_op !== 8'h00) begin n_fail++; $display("FAIL flush_empty: got v=%b op=%h want 0/00", instr_valid, head_op); end
        step;
        n_tests++; if (instr_valid !== 1'b1 || head_op !== 8'h77 || fetch_pc !== 16'h3001) begin n_fail++; $display("FAIL flush_head: got v=%b op=%h pc=%h want 1/77/3001", instr_valid, head_op, fetch_pc); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] p;
        p = 16'h1234;
        isize = 2'd0; advance = 1'b0;
        redirect = 1'b1; redirect_pc = p; #1;
        step; redirect = 1'b0; #1;
        for (int w = 0; w < 6 && !instr_valid; w++) step;
        n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_fill: got %b want 1", instr_valid); end
        advance = 1'b1; #1;
        for (int i = 0; i < 20; i++) begin
            n_tests++;
            if (instr_valid !== 1'b1 || fetch_pc !== 16'(p + 16'(i)) || head_op !== mem[16'(p + 16'(i))]) begin
                n_fail++;
                $display("FAIL b2b_%0d: got v=%b pc=%h op=%h want 1/%h/%h", i, instr_valid, fetch_pc, head_op, 16'(p + 16'(i)), mem[16'(p + 16'(i))]);
            end
            step;
        end
        advance = 1'b0; #1;
    endtask

    task automatic test_random;
        logic [15:0] exp_pc;
        int streak;
        redirect = 1'b1; redirect_pc = 16'($urandom); advance = 1'b0; #1;
        exp_pc = redirect_pc;
        step;
        streak = 0;
        for (int c = 0; c < 400; c++) begin
            isize = 2'($urandom_range(0, 3));
            advance = 1'($urandom_range(0, 1));
            redirect = ($urandom_range(0, 15) == 0);
            redirect_pc = 16'($urandom);
            #1;
            n_tests++; if (fetch_pc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc c=%0d: got %h want %h", c, fetch_pc, exp_pc); end
            if (instr_valid === 1'b1) begin
                streak = 0;
                n_tests++; if (head_op !== mem[exp_pc]) begin n_fail++; $display("FAIL rnd_op c=%0d: got %h want %h", c, head_op, mem[exp_pc]); end
                n_tests++; if (immr !== ref_immr(exp_pc, isize)) begin n_fail++; $display("FAIL rnd_immr c=%0d: got %h want %h", c, immr, ref_immr(exp_pc, isize)); end
            end else begin
                streak++;
                if (streak > 8) begin
                    n_tests++; n_fail++;
                    $display("FAIL rnd_starve c=%0d: got %0d invalid cycles want <= 8", c, streak);
                    streak = 0;
                end
            end
            if (redirect) begin
                exp_pc = redirect_pc;
                streak = 0;
            end else if (advance && instr_valid) begin
                exp_pc = exp_pc + 16'(isize) + 16'd1;
            end
            step;
        end
        redirect = 1'b0; advance = 1'b0; #1;
    endtask

    task automatic test_stall;
        int model;
        redirect = 1'b0; advance = 1'b0; isize = 2'd3;
        rst = 1'b1; step;
        rst = 1'b0; #1;
        model = 0;
        for (int c = 1; c <= 6; c++) begin
`ifdef FETCH_STALL_CNT_EN
            n_tests++; if (stall_cnt !== 16'(model)) begin n_fail++; $display("FAIL stall_c%0d: got %0d want %0d", c, stall_cnt, model); end
`else
            n_tests++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL stall_off_c%0d: got %0d want 0", c, stall_cnt); end
`endif
            // 4-byte instruction at PC 0: valid from cycle 4 after reset
            n_tests++; if (instr_valid !== (c >= 4)) begin n_fail++; $display("FAIL stall_valid_c%0d: got %b want %b", c, instr_valid, (c >= 4)); end
            if (!instr_valid) model++;
            step;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; advance = 1'b0; isize = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset;
        test_long_instr;
        test_odd_redirect;
        test_redirect_flush;
        test_back_to_back;
        test_random;
        test_stall;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
